reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the single register-file write port (RegWrite/write_reg/write_data) between two producers.
- Producer A is the main pipeline writeback: highest priority, no backpressure.
- Producer B is the multi-cycle unit (mult/div/load): valid/ready handshake, buffered in a DEPTH-entry FIFO, drained in idle write slots.
- Exports a per-register pending vector for the hazard unit, and forces a one-cycle pipeline stall to prevent B starvation.

Parameters:
- DEPTH, 4, FIFO entries for producer B (power of two, ≥2).
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may lose arbitration before wb_stall fires.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  producer A write request this cycle.
- wb_reg  in  5  producer A destination register.
- wb_data  in  DATA_W  producer A write data.
- wb_stall  out  1  registered; pipeline must hold A this cycle, and wb_valid is ignored.
- mc_valid  in  1  producer B offers a result.
- mc_ready  out  1  FIFO can accept; handshake when mc_valid && mc_ready.
- mc_reg  in  5  producer B destination register.
- mc_data  in  DATA_W  producer B result.
- RegWrite  out  1  registered write enable to register file.
- write_reg  out  5  registered write address.
- write_data  out  DATA_W  registered write data.
- pending  out  32  pending[r]=1 while a live B write to r sits in FIFO.
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0) forces:
  - RegWrite=0, write_reg=0, write_data=0, wb_stall=0.
  - FIFO empty, fifo_count=0, all kill bits 0, starve counter 0.
  - pending=0, mc_ready=1.
  - Reset mid-operation discards all buffered B entries; nothing is written.
- FIFO entry = {reg, data, kill}.
- mc_ready = (fifo_count < DEPTH), derived from registered count only. When full, no enqueue happens even if a dequeue occurs the same cycle.
- Enqueue on handshake:
  - mc_reg==0: handshake completes, entry is discarded, count unchanged.
  - Otherwise the entry is written with kill=0.
- a_win = wb_valid && !wb_stall.
- grant_b = fifo nonempty && !a_win. This includes wb_stall cycles.
- Output registers, loaded at edge:
  - a_win && wb_reg!=0: RegWrite<=1, write_reg<=wb_reg, write_data<=wb_data.
  - else grant_b && head.kill==0: RegWrite<=1, write_reg/write_data <= head.
  - else RegWrite<=0; write_reg and write_data hold their values.
- Latency: one cycle from accepted request to RegWrite pulse.
- Dequeue: head is popped whenever grant_b, whether killed or not. A killed head consumes the slot and produces no write.
- Kill rule (WAW ordering):
  - a_win with wb_reg!=0 sets kill on every valid FIFO entry whose reg==wb_reg, at the same edge.
  - An entry enqueued in that same cycle is not killed; it is treated as younger.
- A write to r0 from either producer never asserts RegWrite.
- pending:
  - pending[r] = OR over valid, non-killed entries with reg==r.
  - pending[0]=0 always.
  - Combinational from state only; no input-to-output path.
- Starvation counter:
  - Increments on each cycle with FIFO nonempty && a_win.
  - Clears on grant_b or when the FIFO is empty.
  - When it equals STARVE_LIMIT-1 on a waiting cycle: wb_stall<=1 for the next cycle and the counter clears.
  - wb_stall is never high two consecutive cycles.
- Simultaneous enqueue and dequeue when not full: count unchanged, pointers wrap modulo DEPTH.
- Empty FIFO with no A request: RegWrite<=0, wb_stall stays 0.

Test Plan:
1. Release reset; A writes r5=12 → next cycle RegWrite=1, write_reg=5, write_data=12. The following cycle RegWrite=0.
2. A writes r0=7, and separately B hands over r0=9 → RegWrite stays 0 throughout, fifo_count stays 0, mc_ready stays 1.
3. B enqueues r3=0xAA while A is valid for 3 cycles (r1, r2, r4):
   - pending[3]=1 during those cycles.
   - First idle cycle grants B: RegWrite r3=0xAA next cycle.
   - pending[3] clears when the entry is popped.
4. Hold wb_valid=1 continuously while B pushes 5 results:
   - After 4 entries: mc_ready=0, fifo_count=4.
   - After 8 waiting cycles: wb_stall=1 for exactly one cycle and the head is written.
   - fifo_count=3, then mc_ready=1.
5. B enqueues r7=1, then A writes r7=2 while the entry is still queued:
   - pending[7] drops immediately.
   - Register file sees only r7=2.
   - The killed entry is later popped with RegWrite=0 and fifo_count decrements.
6. Assert rst_n=0 asynchronously mid-drain with 3 entries queued → RegWrite, write_reg, write_data, wb_stall, fifo_count and pending go to 0 immediately, without waiting for a clock edge. After release, no stale writes occur.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port between the writeback pipe (A, priority) and a FIFO-buffered multi-cycle unit (B).
// Latency: one cycle to RegWrite. Backpressure: mc_ready drops when the FIFO is full; A is held by a one-cycle wb_stall when B starves.
module reg_write_arbiter #(
  parameter  int DEPTH        = 4,
  parameter  int STARVE_LIMIT = 8,
  parameter  int DATA_W       = 32,
  localparam int AW           = $clog2(DEPTH),
  localparam int CW           = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [4:0]        mc_reg,
  input  logic [DATA_W-1:0] mc_data,
  output logic              RegWrite,
  output logic [4:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [31:0]       pending,
  output logic [CW-1:0]     fifo_count
);

  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    logic              kill;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              wb_stall_q, wb_stall_d;
  logic              regwrite_q, regwrite_d;
  logic [4:0]        write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic [DEPTH-1:0]  ent_vld;
  logic              empty, a_win, a_wr, grant_b, push;
  entry_t            head;
  logic [31:0]       pend;

  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    logic [AW-1:0] off;
    assign off        = AW'(g) - rd_ptr_q;
    assign ent_vld[g] = {1'b0, off} < count_q;
  end

  assign empty    = (count_q == '0);
  assign mc_ready = (count_q < CW'(DEPTH));
  assign a_win    = wb_valid && !wb_stall_q;
  assign a_wr     = a_win && (wb_reg != 5'd0);
  assign grant_b  = !empty && !a_win;
  assign push     = mc_valid && mc_ready && (mc_reg != 5'd0);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    mem_d = mem_q;
    if (a_wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && mem_q[i].rd == wb_reg) mem_d[i].kill = 1'b1;
      end
    end
    // The write slot is never live when push is allowed, so a same-cycle entry escapes the kill.
    if (push) mem_d[wr_ptr_q] = '{rd: mc_reg, data: mc_data, kill: 1'b0};
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (grant_b) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, grant_b})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d   = starve_q;
    wb_stall_d = 1'b0;
    if (empty || grant_b) begin
      starve_d = '0;
    end else if (a_win) begin
      if (starve_q == SW'(STARVE_LIMIT - 1)) begin
        wb_stall_d = 1'b1;
        starve_d   = '0;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_comb begin
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (a_wr) begin
      regwrite_d   = 1'b1;
      write_reg_d  = wb_reg;
      write_data_d = wb_data;
    end else if (grant_b && !head.kill) begin
      regwrite_d   = 1'b1;
      write_reg_d  = head.rd;
      write_data_d = head.data;
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && !mem_q[i].kill) pend[mem_q[i].rd] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      wb_stall_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      wb_stall_q   <= wb_stall_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign wb_stall   = wb_stall_q;
  assign RegWrite   = regwrite_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign pending    = pend;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: priority, r0 suppression, kill ordering, starvation stall, async reset.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, mc_valid, mc_ready, wb_stall, RegWrite;
  logic [4:0]  wb_reg, mc_reg, write_reg;
  logic [31:0] wb_data, mc_data, write_data, pending;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_reg(mc_reg), .mc_data(mc_data),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_regwrite"}, 32'(RegWrite), 32'd0);
    chk({tag, "_write_reg"}, 32'(write_reg), 32'd0);
    chk({tag, "_write_data"}, write_data, 32'd0);
    chk({tag, "_wb_stall"}, 32'(wb_stall), 32'd0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_pending"}, pending, 32'd0);
    chk({tag, "_mc_ready"}, 32'(mc_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    mc_valid = 1'b0; mc_reg = '0; mc_data = '0;
    #12;
    chk_idle_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: A writes r5=12
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'd12;
    tick();
    chk("t1_regwrite", 32'(RegWrite), 32'd1);
    chk("t1_write_reg", 32'(write_reg), 32'd5);
    chk("t1_write_data", write_data, 32'd12);
    wb_valid = 1'b0;
    tick();
    chk("t1_regwrite_low", 32'(RegWrite), 32'd0);
    chk("t1_write_reg_hold", 32'(write_reg), 32'd5);

    // 2: r0 writes from both producers are dropped
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'd7;
    mc_valid = 1'b1; mc_reg = 5'd0; mc_data = 32'd9;
    chk("t2_mc_ready_pre", 32'(mc_ready), 32'd1);
    tick();
    chk("t2_regwrite", 32'(RegWrite), 32'd0);
    chk("t2_fifo_count", 32'(fifo_count), 32'd0);
    chk("t2_mc_ready", 32'(mc_ready), 32'd1);
    wb_valid = 1'b0; mc_valid = 1'b0;
    tick();
    chk("t2_regwrite_after", 32'(RegWrite), 32'd0);
    chk("t2_fifo_count_after", 32'(fifo_count), 32'd0);

    // 3: B r3=0xAA waits behind three A writes
    wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h11;
    mc_valid = 1'b1; mc_reg = 5'd3; mc_data = 32'hAA;
    tick();
    mc_valid = 1'b0;
    chk("t3_pending_a", pending, 32'h8);
    chk("t3_fifo_count", 32'(fifo_count), 32'd1);
    chk("t3_write_reg_a1", 32'(write_reg), 32'd1);
    wb_reg = 5'd2; wb_data = 32'h22;
    tick();
    chk("t3_pending_b", pending, 32'h8);
    chk("t3_write_reg_a2", 32'(write_reg), 32'd2);
    wb_reg = 5'd4; wb_data = 32'h44;
    tick();
    chk("t3_pending_c", pending, 32'h8);
    chk("t3_write_reg_a4", 32'(write_reg), 32'd4);
    wb_valid = 1'b0;
    tick();
    chk("t3_b_regwrite", 32'(RegWrite), 32'd1);
    chk("t3_b_write_reg", 32'(write_reg), 32'd3);
    chk("t3_b_write_data", write_data, 32'hAA);
    chk("t3_pending_clear", pending, 32'd0);
    chk("t3_fifo_empty", 32'(fifo_count), 32'd0);
    tick();
    chk("t3_regwrite_low", 32'(RegWrite), 32'd0);

    // 4: continuous A traffic, B pushes r11..r15 and starves
    wb_valid = 1'b1; wb_reg = 5'd10; wb_data = 32'h55;
    for (int i = 0; i < 4; i++) begin
      mc_valid = 1'b1; mc_reg = 5'(11 + i); mc_data = 32'(32'h10B + i);
      tick();
      chk("t4_no_stall_fill", 32'(wb_stall), 32'd0);
    end
    chk("t4_full_count", 32'(fifo_count), 32'd4);
    chk("t4_full_ready", 32'(mc_ready), 32'd0);
    mc_reg = 5'd15; mc_data = 32'h10F;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_no_stall_wait", 32'(wb_stall), 32'd0);
      chk("t4_ready_low", 32'(mc_ready), 32'd0);
    end
    tick();
    chk("t4_stall_high", 32'(wb_stall), 32'd1);
    chk("t4_a_write_reg", 32'(write_reg), 32'd10);
    chk("t4_count_before_pop", 32'(fifo_count), 32'd4);
    tick();
    chk("t4_stall_one_cycle", 32'(wb_stall), 32'd0);
    chk("t4_head_regwrite", 32'(RegWrite), 32'd1);
    chk("t4_head_write_reg", 32'(write_reg), 32'd11);
    chk("t4_head_write_data", write_data, 32'h10B);
    chk("t4_count_3", 32'(fifo_count), 32'd3);
    chk("t4_ready_back", 32'(mc_ready), 32'd1);
    tick();
    chk("t4_fifth_pushed", 32'(fifo_count), 32'd4);
    chk("t4_a_again", 32'(write_reg), 32'd10);
    wb_valid = 1'b0; mc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_drain_regwrite", 32'(RegWrite), 32'd1);
      chk("t4_drain_write_reg", 32'(write_reg), 32'(12 + i));
      chk("t4_drain_write_data", write_data, 32'(32'h10C + i));
    end
    chk("t4_drained", 32'(fifo_count), 32'd0);

    // 5: A overwrites a queued B entry for r7
    mc_valid = 1'b1; mc_reg = 5'd7; mc_data = 32'd1;
    tick();
    chk("t5_pending_set", pending, 32'h80);
    chk("t5_regwrite_idle", 32'(RegWrite), 32'd0);
    mc_valid = 1'b0;
    wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'd2;
    tick();
    chk("t5_pending_killed", pending, 32'd0);
    chk("t5_a_write_reg", 32'(write_reg), 32'd7);
    chk("t5_a_write_data", write_data, 32'd2);
    chk("t5_count_still_1", 32'(fifo_count), 32'd1);
    wb_valid = 1'b0;
    tick();
    chk("t5_killed_no_write", 32'(RegWrite), 32'd0);
    chk("t5_killed_popped", 32'(fifo_count), 32'd0);
    chk("t5_data_held", write_data, 32'd2);

    // Same-cycle A and B to r9: the new entry is younger and survives
    wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h33;
    mc_valid = 1'b1; mc_reg = 5'd9; mc_data = 32'h44;
    tick();
    chk("t5b_a_data", write_data, 32'h33);
    chk("t5b_pending", pending, 32'h200);
    wb_valid = 1'b0; mc_valid = 1'b0;
    tick();
    chk("t5b_b_regwrite", 32'(RegWrite), 32'd1);
    chk("t5b_b_data", write_data, 32'h44);

    // 6: asynchronous reset mid-drain
    wb_valid = 1'b1; wb_reg = 5'd20; wb_data = 32'hE;
    for (int i = 0; i < 4; i++) begin
      mc_valid = 1'b1; mc_reg = 5'(21 + i); mc_data = 32'(32'h200 + i);
      tick();
    end
    wb_valid = 1'b0; mc_valid = 1'b0;
    tick();
    chk("t6_drain_reg", 32'(write_reg), 32'd21);
    chk("t6_three_left", 32'(fifo_count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_reset("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_stale_write", 32'(RegWrite), 32'd0);
      chk("t6_fifo_empty", 32'(fifo_count), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
